sub_bytes_serial: RTL and testbench
===================================

SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

Interface
REQ-001 The module SHALL have parameter MSB_FIRST, default 1, meaning byte 0 = in_state[127:120] when 1, or in_state[7:0] when 0.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port clear, input, 1 bit: synchronous abort; drops any block in flight.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_state holds a block to substitute.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept in_state.
REQ-007 The module SHALL have port in_state, input, 128 bits: AES state to run through SubBytes.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_state holds a finished block.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer takes out_state.
REQ-010 The module SHALL have port out_state, output, 128 bits: substituted state, with byte positions preserved.
REQ-011 The module SHALL have port busy, output, 1 bit: high in SUB or DONE.

Function
REQ-012 The module SHALL instantiate exactly one combinational sbox_calik and time-multiplex it across the 16 state bytes.
REQ-013 The module SHALL implement FSM states IDLE, SUB and DONE; in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-014 In IDLE, when in_valid&&in_ready, the module SHALL capture in_state into a 128-bit buffer, clear the 4-bit byte counter and enter SUB.
REQ-015 In SUB, each cycle, the module SHALL pass buffer byte[cnt] through the S-box and write the result back into byte[cnt]; cnt SHALL then increment.
REQ-016 When cnt==15 in SUB (and the last write has been made), the module SHALL enter DONE; cnt SHALL NOT wrap into a second pass.
REQ-017 Latency SHALL be 16 cycles: with acceptance at edge N, out_valid SHALL be high after edge N+16.
REQ-018 In DONE, out_state and out_valid SHALL hold stable until out_ready is high; on that edge the module SHALL go to IDLE.
REQ-019 Acceptance in the cycle immediately after an output handshake SHALL be possible, giving a throughput of one block per 18 cycles.
REQ-020 clear SHALL dominate every other input: on an edge with clear high, the module SHALL go to IDLE with cnt=0 and out_valid=0, whatever the state or handshakes.
REQ-021 in_state changes while not accepted SHALL have no effect; in_valid without in_ready SHALL NOT be lost or registered.

Reset
REQ-022 On reset_n low, the module SHALL go to IDLE asynchronously, with cnt=0, buffer=0, out_valid=0, out_state=0, busy=0 and in_ready=1 once reset is released.
REQ-023 Reset asserted mid-SUB or mid-DONE SHALL discard the block; no output handshake SHALL occur for it.

Configuration
REQ-024 The module SHALL support macro SUB_BYTES_SERIAL_PIPE_EN.
REQ-025 With SUB_BYTES_SERIAL_PIPE_EN defined, the module SHALL register the S-box output (byte plus index) before write-back, entering DONE one cycle after the last write; latency SHALL be 17 cycles and throughput one block per 19 cycles.
REQ-026 Without SUB_BYTES_SERIAL_PIPE_EN, the module SHALL use a direct combinational write-back with 16-cycle latency.

Verification
REQ-027 The bench SHALL drive in_state=00112233445566778899aabbccddeeff with out_ready=1 and check out_state=638293c31bfc33f5c4eeacea4bc12816 with out_valid exactly 16 cycles after acceptance (17 with PIPE_EN).
REQ-028 The bench SHALL drive in_state=0 and check out_state=63636363636363636363636363636363; in_ready SHALL be 0 for the whole block.
REQ-029 The bench SHALL hold out_ready=0 for 10 cycles after out_valid and check that out_state is unchanged, that in_ready=0, and that there is a single handshake when out_ready rises.
REQ-030 The bench SHALL assert clear at cnt=7, then check IDLE next cycle, out_valid never rises, and that a following block of all ff gives all 16.
REQ-031 The bench SHALL pulse reset_n low mid-SUB and check that all outputs drop to 0 immediately (before the clock edge) and that in_ready=1 after release.
REQ-032 The bench SHALL run two back-to-back blocks with in_valid held high and check that the second is accepted on the cycle after the first output handshake and that both results are correct.

Source files
------------

// File: rtl/sub_bytes_serial.sv
// Byte-serial AES SubBytes: one shared S-box is applied to the 16 state bytes over 16 cycles.
// The optional macro SUB_BYTES_SERIAL_PIPE_EN registers the S-box result before write-back (17-cycle latency).

// Combinational AES S-box: GF(2^8) inverse computed as x^254, followed by the affine map.
module sbox_calik (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Addition chain to x^254; an input of 0 maps to 0, as AES requires.
    always_comb begin
        x2   = gf_mul(a_i, a_i);
        x3   = gf_mul(x2, a_i);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sub_bytes_serial #(
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int unsigned SW = 128;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   buf_q, buf_d;
    logic [BW-1:0]   sb_in, sb_out;

    // Bit offset of byte idx inside the 128-bit state; 15-idx equals ~idx for 4 bits.
    function automatic logic [6:0] byte_lsb(input logic [CW-1:0] idx);
        return (MSB_FIRST != 0) ? {~idx, 3'b000} : {idx, 3'b000};
    endfunction

    assign sb_in = buf_q[byte_lsb(cnt_q) +: BW];

    sbox_calik u_sbox (
        .a_i (sb_in),
        .s_o (sb_out)
    );

`ifdef SUB_BYTES_SERIAL_PIPE_EN
    logic          pv_q, pv_d;
    logic [CW-1:0] pidx_q, pidx_d;
    logic [BW-1:0] pbyte_q, pbyte_d;
    logic          drain_q, drain_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            pbyte_q <= '0;
            drain_q <= 1'b0;
        end else begin
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            pbyte_q <= pbyte_d;
            drain_q <= drain_d;
        end
    end

    // Issue one byte per cycle into the pipe register, write it back one cycle later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        pv_d    = 1'b0;
        pidx_d  = pidx_q;
        pbyte_d = pbyte_q;
        drain_d = drain_q;
        if (pv_q) buf_d[byte_lsb(pidx_q) +: BW] = pbyte_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_state;
                    cnt_d   = '0;
                    drain_d = 1'b0;
                    state_d = SUB;
                end
            end
            SUB: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = DONE;
                end else begin
                    pv_d    = 1'b1;
                    pidx_d  = cnt_q;
                    pbyte_d = sb_out;
                    if (cnt_q == CW'(15)) drain_d = 1'b1;
                    else                  cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            pv_d    = 1'b0;
            drain_d = 1'b0;
        end
    end
`else
    // Direct write-back: byte cnt is substituted in place every SUB cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_state;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                buf_d[byte_lsb(cnt_q) +: BW] = sb_out;
                if (cnt_q == CW'(15)) state_d = DONE;
                else                  cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SUB) || (state_q == DONE);
    assign out_state = buf_q;
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed self-checking bench for sub_bytes_serial (default byte order, MSB_FIRST=1).
`timescale 1ns/1ps
module tb_sub_bytes_serial;
`ifdef SUB_BYTES_SERIAL_PIPE_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif
    localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] FF_IN   = {16{8'hff}};
    localparam logic [127:0] FF_OUT  = {16{8'h16}};
    localparam logic [127:0] ONE_IN  = {16{8'h01}};
    localparam logic [127:0] ONE_OUT = {16{8'h7c}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    sub_bytes_serial #(.MSB_FIRST(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset_n && out_valid && out_ready) hs_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b out_state=%h, want 0/0/0", out_valid, busy, out_state);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vector();
        bit early = 0;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL vec_ready: in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1; in_state = VEC_IN;
        tick();
        in_valid = 1'b0; in_state = 128'hdeadbeef_00000000_12345678_9abcdef0;
        for (int c = 1; c < LAT; c++) begin
            tick();
            if (out_valid !== 1'b0) early = 1;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL vec_latency_early: out_valid rose before %0d cycles", LAT);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_state !== VEC_OUT) begin
            errors++;
            $display("FAIL vec_result: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, VEC_OUT);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL vec_return_idle: in_ready=%b out_valid=%b busy=%b, want 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_zero();
        bit ready_seen = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_state = '0;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            if (in_ready !== 1'b0) ready_seen = 1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL zero_in_ready: in_ready was 1 during block, want 0");
        end
        checks++;
        if (out_valid !== 1'b1 || out_state !== ZERO_OUT) begin
            errors++;
            $display("FAIL zero_result: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, ZERO_OUT);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit bad = 0;
        int hs0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = VEC_IN;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= LAT; c++) tick();
        hs0 = hs_cnt;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || out_state !== VEC_OUT || in_ready !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b out_state=%h, want 1/0/%h", out_valid, in_ready, out_state, VEC_OUT);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (hs_cnt - hs0 !== 1) begin
            errors++;
            $display("FAIL bp_single_handshake: handshakes=%0d want 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_clear();
        bit rose = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_state = VEC_IN;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: in_ready=%b busy=%b out_valid=%b, want 1/0/0", in_ready, busy, out_valid);
        end
        for (int c = 0; c < 25; c++) begin
            if (out_valid !== 1'b0) rose = 1;
            tick();
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL clear_no_output: out_valid rose after clear, want 0");
        end
        in_valid = 1'b1; in_state = FF_IN;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= LAT; c++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_state !== FF_OUT) begin
            errors++;
            $display("FAIL clear_next_block: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, FF_OUT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit rose = 0;
        int hs0 = hs_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; in_state = VEC_IN;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_state !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%b busy=%b out_state=%h, want 0/0/0", out_valid, busy, out_state);
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: in_ready=%b want 1", in_ready);
        end
        for (int c = 0; c < 25; c++) begin
            if (out_valid !== 1'b0) rose = 1;
            tick();
        end
        checks++;
        if (rose || hs_cnt != hs0) begin
            errors++;
            $display("FAIL reset_mid_discard: handshakes=%0d want 0", hs_cnt - hs0);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_state = VEC_IN;
        tick();
        in_state = ONE_IN;
        for (int c = 1; c <= LAT; c++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_state !== VEC_OUT) begin
            errors++;
            $display("FAIL b2b_first: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, VEC_OUT);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b in_ready=%b, want 1/0", busy, in_ready);
        end
        for (int c = 1; c <= LAT; c++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_state !== ONE_OUT) begin
            errors++;
            $display("FAIL b2b_second: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, ONE_OUT);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vector();
        test_zero();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
